// File: rtl/wait_merge_sched.sv
`default_nettype none
// ============================================================================
// Module   : wait_merge_sched
// Brief    : N-way drive/free join with settle delay, watchdog and overflow flag
// Revision : 1.0
// ============================================================================
module wait_merge_sched #(
   parameter int NUM_IN   = 2,
   parameter int FIRE_DLY = 1,
   parameter int TO_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_IN-1:0] i_drive,
   output logic [NUM_IN-1:0] o_free,
   input  logic [NUM_IN-1:0] i_en_mask,
   output logic              o_driveNext,
   input  logic              i_freeNext,
   input  logic [TO_W-1:0]   i_timeout_lim,
   output logic              o_busy,
   output logic              o_timeout,
   output logic [NUM_IN-1:0] o_missing,
   output logic              o_ovf,
   input  logic              i_clr_err
);

   localparam logic [7:0] c_FIRE_DLY = 8'(FIRE_DLY);

   typedef enum logic [1:0] {
      S_COLLECT   = 2'd0,
      S_FIRE      = 2'd1,
      S_WAIT_FREE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_IN-1:0]   r_mask;
   logic [NUM_IN-1:0]   r_pend;
   logic [NUM_IN-1:0]   r_free;
   logic [NUM_IN-1:0]   r_missing;
   logic [7:0]          r_dly;
   logic [TO_W-1:0]     r_to_cnt;
   logic                r_timeout;
   logic                r_ovf;

   logic [NUM_IN-1:0]   w_drv_en;
   logic [NUM_IN-1:0]   w_acc;
   logic                w_ovf_ev;
   logic                w_join;
   logic                w_fire_now;
   logic                w_free_ev;
   logic                w_to_run;
   logic                w_to_hit;
   logic [TO_W-1:0]     w_to_inc;

   always_comb begin
      w_drv_en   = i_drive & r_mask;
      w_acc      = '0;
      w_ovf_ev   = 1'b0;
      w_join     = 1'b0;
      if (r_state == S_COLLECT) begin
         w_acc    = w_drv_en & ~r_pend;
         w_ovf_ev = |(w_drv_en & r_pend);
         w_join   = (r_mask != '0) && ((r_pend | w_drv_en) == r_mask);
      end else begin
         w_ovf_ev = |w_drv_en;
      end
      w_fire_now = (r_state == S_FIRE) && (r_dly == 8'd0);
      w_free_ev  = (r_state == S_WAIT_FREE) && i_freeNext;
      w_to_run   = (r_state == S_COLLECT) && (r_pend != '0) && (i_timeout_lim != '0);
      w_to_inc   = r_to_cnt + TO_W'(1);
      // fires once on the increment that lands on the limit, then the count holds
      w_to_hit   = w_to_run && (r_to_cnt != i_timeout_lim) && (w_to_inc == i_timeout_lim);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT:   if (w_join)     w_state_nxt = S_FIRE;
         S_FIRE:      if (w_fire_now) w_state_nxt = S_WAIT_FREE;
         S_WAIT_FREE: if (w_free_ev)  w_state_nxt = S_COLLECT;
         default:                     w_state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask    <= '0;
         r_pend    <= '0;
         r_free    <= '0;
         r_dly     <= 8'd0;
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
         r_missing <= '0;
         r_ovf     <= 1'b0;
      end else begin
         // mask is frozen once any token of the round has been accepted
         if ((r_state == S_COLLECT) && (r_pend == '0) && (w_acc == '0)) begin
            r_mask <= i_en_mask;
         end

         if (w_free_ev) begin
            r_pend <= '0;
         end else begin
            r_pend <= r_pend | w_acc;
         end

         r_free <= w_free_ev ? r_mask : '0;

         if (w_join) begin
            r_dly <= c_FIRE_DLY;
         end else if ((r_state == S_FIRE) && (r_dly != 8'd0)) begin
            r_dly <= r_dly - 8'd1;
         end

         if (!w_to_run) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != i_timeout_lim) begin
            r_to_cnt <= w_to_inc;
         end

         if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_missing <= r_mask & ~r_pend;
         end else if (i_clr_err) begin
            r_timeout <= 1'b0;
            r_missing <= '0;
         end

         if (w_ovf_ev) begin
            r_ovf <= 1'b1;
         end else if (i_clr_err) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_free      = r_free;
   assign o_driveNext = w_fire_now;
   assign o_busy      = (r_pend != '0) || (r_state != S_COLLECT);
   assign o_timeout   = r_timeout;
   assign o_missing   = r_missing;
   assign o_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/wait_merge_sched.md
Name: wait_merge_sched

Overview:
- Clocked join controller for the two-sided (generalised to NUM_IN) drive/free micropipeline merge.
- Collects one drive pulse from every enabled producer, then issues a single downstream drive after a programmable settle delay.
- Waits for the downstream free, then returns free pulses to all enabled producers.
- Watchdog flags producers that never arrive; overflow flag catches protocol violations. Sits between the producer stages and the merged consumer stage of the datapath.

Parameters:
- NUM_IN, 2, number of producer (drive/free) channels, 2..16
- FIRE_DLY, 1, extra cycles between join completion and o_driveNext (0..255); models matched-delay settle time
- TO_W, 16, width of watchdog counter and i_timeout_lim

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_drive  in  NUM_IN  per-producer drive pulses, one cycle high per token
- o_free  out  NUM_IN  per-producer free pulses, one cycle high
- i_en_mask  in  NUM_IN  1 = producer participates in join; sampled only in IDLE/COLLECT with no pending token
- o_driveNext  out  1  merged drive pulse to consumer, one cycle high
- i_freeNext  in  1  consumer free pulse, one cycle high
- i_timeout_lim  in  TO_W  watchdog limit in cycles; 0 disables
- o_busy  out  1  high when any token pending or state != COLLECT
- o_timeout  out  1  sticky watchdog flag
- o_missing  out  NUM_IN  enabled inputs not yet arrived, latched at timeout
- o_ovf  out  1  sticky protocol-overflow flag
- i_clr_err  in  1  synchronous clear of o_timeout, o_missing, o_ovf

Behaviour:
- Reset (rst=0, async): state=COLLECT, pending=0, all counters 0, every output 0; mask register = 0.
- Registered mask m: loaded from i_en_mask every cycle while state=COLLECT and pending=0.
- States: COLLECT, FIRE, WAIT_FREE.
- COLLECT: pending[i] set on i_drive[i]&m[i]; drives with m[i]=0 ignored. When (pending | (i_drive&m)) == m and m != 0, go FIRE at that edge, load dly_cnt=FIRE_DLY.
- m == 0: never leave COLLECT.
- FIRE: if dly_cnt==0, assert o_driveNext next cycle and go WAIT_FREE; else decrement.
- Latency: o_driveNext is high exactly FIRE_DLY+1 cycles after the cycle in which the last required drive was high.
- WAIT_FREE: on i_freeNext, o_free <= m (one cycle, next cycle), pending cleared, state -> COLLECT.
- i_freeNext in COLLECT/FIRE: ignored, no flag.
- Overflow: i_drive[i]&m[i] while pending[i]=1, or any enabled drive during FIRE/WAIT_FREE, sets o_ovf. The offending pulse is dropped; existing pending is unchanged. This includes the cycle where i_freeNext is sampled.
- Drive in the cycle o_free is high is legal and counts toward the next round.
- Watchdog: in COLLECT with pending != 0 and limit != 0, to_cnt increments each cycle, cleared when pending==0 or on leaving COLLECT.
- When to_cnt reaches i_timeout_lim: o_timeout <= 1 and o_missing <= m & ~pending. Operation continues; a late drive still completes the join.
- i_clr_err=1 clears flags that cycle; a simultaneous set event wins over the clear.
- Reset asserted mid-operation: immediate return to reset values. No o_free is issued for the aborted tokens.

Test Plan:
- NUM_IN=2, FIRE_DLY=1, mask=11: drive0 @t0, drive1 @t3 -> o_driveNext high @t5 only. freeNext @t8 -> o_free=11 @t9, o_busy low @t9.
- Simultaneous drives 11 @t0, FIRE_DLY=0 -> o_driveNext @t1. Drive0 again @t9 while o_free high -> accepted, pending=01, o_ovf=0.
- mask=01 -> single drive0 fires. drive1 pulses are ignored; o_free=01 only.
- Duplicate drive0 @t0,t2 before drive1 -> o_ovf=1 @t3. Fire still occurs once after drive1. i_clr_err clears o_ovf.
- timeout_lim=10, only drive0 @t0 -> o_timeout=1, o_missing=10 at ~t11. Drive1 @t20 -> normal fire; limit=0 never flags.
- rst low during WAIT_FREE -> all outputs 0 immediately. A later freeNext produces no o_free; a new round works normally.
